gate_arbiter: RTL and testbench

- Sequences the single shared parking gate between the entry requester (car at entry loop) and the exit requester (car leaving a chosen slot).
- Edge-detects and latches requests, then arbitrates round-robin between them.
- Validates each grant against occupancy status (capacity, spots) from the parking occupancy FSM.
- Emits one-cycle entry_signal / exit_signal pulses to that FSM and times the door open/close sequence.

---
 rtl/gate_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_gate_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_arbiter.sv
// ============================================================================
// Module      : gate_arbiter
// Description : Round-robin arbiter for the shared parking gate between entry
//               and exit requesters, validated against occupancy status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_arbiter #(
  parameter int OPEN_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_req_slot,
  input  logic [2:0] capacity,
  input  logic [3:0] spots,
  output logic       entry_signal,
  output logic       exit_signal,
  output logic [1:0] exit_slot,
  output logic       door_open,
  output logic       busy,
  output logic       reject_full,
  output logic       reject_slot,
  output logic       last_grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OPEN  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  logic             r_entry_pend;
  logic             r_exit_pend;
  logic             r_entry_prev;
  logic             r_exit_prev;
  logic [1:0]       r_slot_q;
  logic [CNT_W-1:0] r_timer;

  state_t           w_state;
  logic [CNT_W-1:0] w_timer;
  logic             w_entry_sig;
  logic             w_exit_sig;
  logic             w_rej_full;
  logic             w_rej_slot;
  logic             w_door;
  logic [1:0]       w_exit_slot;
  logic             w_last;
  logic             w_busy;
  logic             w_pick_exit;
  logic             w_entry_clr;
  logic             w_exit_clr;
  logic             w_entry_rise;
  logic             w_exit_rise;
  logic             w_entry_pend;
  logic             w_exit_pend;
  logic [1:0]       w_slot_q;

  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer;
    w_entry_sig = 1'b0;
    w_exit_sig  = 1'b0;
    w_rej_full  = 1'b0;
    w_rej_slot  = 1'b0;
    w_door      = door_open;
    w_exit_slot = exit_slot;
    w_last      = last_grant;
    w_pick_exit = 1'b0;
    w_entry_clr = 1'b0;
    w_exit_clr  = 1'b0;

    case (r_state)
      IDLE: begin
        w_door = 1'b0;
        if (r_entry_pend || r_exit_pend) begin
          // A full lot lets the exit go first so the waiting entry can follow.
          if (r_entry_pend && r_exit_pend)
            w_pick_exit = (capacity == 3'd0) || !last_grant;
          else
            w_pick_exit = r_exit_pend;
          w_last = w_pick_exit;
          if (w_pick_exit) begin
            w_exit_clr = 1'b1;
            if (spots[r_slot_q]) begin
              w_exit_sig  = 1'b1;
              w_exit_slot = r_slot_q;
              w_state     = GRANT;
            end else begin
              w_rej_slot = 1'b1;
            end
          end else begin
            w_entry_clr = 1'b1;
            if (capacity == 3'd0) begin
              w_rej_full = 1'b1;
            end else begin
              w_entry_sig = 1'b1;
              w_state     = GRANT;
            end
          end
        end
      end
      GRANT: begin
        w_door  = 1'b1;
        w_timer = c_OPEN_LOAD;
        w_state = OPEN;
      end
      OPEN: begin
        if (r_timer == '0) begin
          w_door  = 1'b0;
          w_timer = c_GAP_LOAD;
          w_state = GAP;
        end else begin
          w_timer = r_timer - 1'b1;
        end
      end
      GAP: begin
        if (r_timer == '0) w_state = IDLE;
        else               w_timer = r_timer - 1'b1;
      end
      default: w_state = IDLE;
    endcase

    w_busy = (w_state != IDLE);
  end

  // A rise while already pending is ignored, so a cleared flag never re-arms on the same edge.
  always_comb begin
    w_entry_rise = entry_req & ~r_entry_prev;
    w_exit_rise  = exit_req & ~r_exit_prev;
    w_entry_pend = w_entry_clr ? 1'b0 : (r_entry_pend | w_entry_rise);
    w_exit_pend  = w_exit_clr ? 1'b0 : (r_exit_pend | w_exit_rise);
    w_slot_q     = (w_exit_rise && !r_exit_pend) ? exit_req_slot : r_slot_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_entry_pend <= 1'b0;
      r_exit_pend  <= 1'b0;
      r_entry_prev <= 1'b0;
      r_exit_prev  <= 1'b0;
      r_slot_q     <= 2'd0;
      r_timer      <= '0;
      entry_signal <= 1'b0;
      exit_signal  <= 1'b0;
      exit_slot    <= 2'd0;
      door_open    <= 1'b0;
      busy         <= 1'b0;
      reject_full  <= 1'b0;
      reject_slot  <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_entry_pend <= w_entry_pend;
      r_exit_pend  <= w_exit_pend;
      r_entry_prev <= entry_req;
      r_exit_prev  <= exit_req;
      r_slot_q     <= w_slot_q;
      r_timer      <= w_timer;
      entry_signal <= w_entry_sig;
      exit_signal  <= w_exit_sig;
      exit_slot    <= w_exit_slot;
      door_open    <= w_door;
      busy         <= w_busy;
      reject_full  <= w_rej_full;
      reject_slot  <= w_rej_slot;
      last_grant   <= w_last;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_arbiter.sv
// ============================================================================
// Module      : tb_gate_arbiter
// Description : Directed self-checking bench for gate_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req;
  logic       exit_req;
  logic [1:0] exit_req_slot;
  logic [2:0] capacity;
  logic [3:0] spots;
  logic       entry_signal;
  logic       exit_signal;
  logic [1:0] exit_slot;
  logic       door_open;
  logic       busy;
  logic       reject_full;
  logic       reject_slot;
  logic       last_grant;

  int n_chk = 0;
  int n_err = 0;
  int n_entry, n_exit, n_rf, n_rs, n_door_hi, n_open, n_bad;
  logic       prev_door;
  logic [3:0] p_pulse;

  gate_arbiter #(.OPEN_CYCLES(8), .GAP_CYCLES(2), .CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .exit_req_slot (exit_req_slot),
    .capacity      (capacity),
    .spots         (spots),
    .entry_signal  (entry_signal),
    .exit_signal   (exit_signal),
    .exit_slot     (exit_slot),
    .door_open     (door_open),
    .busy          (busy),
    .reject_full   (reject_full),
    .reject_slot   (reject_slot),
    .last_grant    (last_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    n_entry = 0; n_exit = 0; n_rf = 0; n_rs = 0;
    n_door_hi = 0; n_open = 0;
    prev_door = door_open;
    p_pulse   = {entry_signal, exit_signal, reject_full, reject_slot};
  endtask

  // Advance n edges, sampling 1 time unit after each edge.
  task automatic run(input int n);
    logic [3:0] cur;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cur = {entry_signal, exit_signal, reject_full, reject_slot};
      if ($countones(cur) > 1)  n_bad++;
      if ((cur & p_pulse) != 0) n_bad++;
      p_pulse = cur;
      n_entry   += int'(entry_signal);
      n_exit    += int'(exit_signal);
      n_rf      += int'(reject_full);
      n_rs      += int'(reject_slot);
      n_door_hi += int'(door_open);
      if (door_open && !prev_door) n_open++;
      prev_door = door_open;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    entry_req = 1'b0; exit_req = 1'b0; exit_req_slot = 2'd0;
    capacity = 3'd4; spots = 4'b0000;
    @(posedge clk); #1;
    chk("rst_door", door_open, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last_grant", last_grant, 1);
    chk("rst_exit_slot", exit_slot, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    clr_cnt();
  endtask

  initial begin
    n_bad = 0;

    // 1: single entry pass
    do_reset();
    entry_req = 1'b1;
    run(1);
    chk("t1_no_early_signal", entry_signal, 0);
    run(1);
    chk("t1_entry_signal", entry_signal, 1);
    chk("t1_last_grant", last_grant, 0);
    chk("t1_busy_grant", busy, 1);
    run(1);
    chk("t1_entry_pulse_end", entry_signal, 0);
    chk("t1_door_up", door_open, 1);
    run(9);
    chk("t1_busy_in_gap", busy, 1);
    chk("t1_door_closed", door_open, 0);
    run(1);
    chk("t1_busy_low", busy, 0);
    chk("t1_door_cycles", n_door_hi, 8);
    chk("t1_entries", n_entry, 1);

    // 2: simultaneous entry/exit, entry first
    do_reset();
    capacity = 3'd2; spots = 4'b0011;
    entry_req = 1'b1; exit_req = 1'b1; exit_req_slot = 2'd1;
    run(2);
    chk("t2_entry_first", entry_signal, 1);
    chk("t2_no_exit_yet", exit_signal, 0);
    chk("t2_last_grant0", last_grant, 0);
    run(12);
    chk("t2_exit_signal", exit_signal, 1);
    chk("t2_exit_slot", exit_slot, 1);
    chk("t2_last_grant1", last_grant, 1);
    run(12);
    chk("t2_openings", n_open, 2);
    chk("t2_door_cycles", n_door_hi, 16);
    chk("t2_idle", busy, 0);

    // 3: full lot rejects entry once
    do_reset();
    capacity = 3'd0; spots = 4'b1111;
    entry_req = 1'b1;
    run(2);
    chk("t3_reject_full", reject_full, 1);
    chk("t3_busy", busy, 0);
    chk("t3_last_grant", last_grant, 0);
    run(6);
    chk("t3_reject_count", n_rf, 1);
    chk("t3_no_entry", n_entry, 0);
    chk("t3_door_never", n_door_hi, 0);

    // 4: full lot, exit wins despite last_grant=1
    do_reset();
    capacity = 3'd0; spots = 4'b1111;
    entry_req = 1'b1; exit_req = 1'b1; exit_req_slot = 2'd3;
    run(2);
    chk("t4_exit_first", exit_signal, 1);
    chk("t4_exit_slot", exit_slot, 3);
    chk("t4_last_grant1", last_grant, 1);
    chk("t4_no_entry", entry_signal, 0);
    capacity = 3'd1; spots = 4'b0111;
    run(12);
    chk("t4_entry_next", entry_signal, 1);
    chk("t4_last_grant0", last_grant, 0);
    run(12);
    chk("t4_openings", n_open, 2);
    chk("t4_no_reject", n_rf, 0);

    // 5: exit from unoccupied slot
    do_reset();
    capacity = 3'd2; spots = 4'b0011;
    exit_req = 1'b1; exit_req_slot = 2'd1;
    run(2);
    chk("t5_prior_exit", exit_signal, 1);
    exit_req = 1'b0;
    run(11);
    chk("t5_prior_idle", busy, 0);
    exit_req = 1'b1; exit_req_slot = 2'd2;
    run(2);
    chk("t5_reject_slot", reject_slot, 1);
    chk("t5_no_exit_signal", exit_signal, 0);
    chk("t5_exit_slot_kept", exit_slot, 1);
    chk("t5_busy", busy, 0);
    exit_req_slot = 2'd0;
    run(3);
    chk("t5_reject_count", n_rs, 1);
    chk("t5_exit_count", n_exit, 1);

    // 6: async reset during OPEN, entry held through release
    do_reset();
    entry_req = 1'b1;
    run(2);
    chk("t6_entry_signal", entry_signal, 1);
    exit_req = 1'b1; exit_req_slot = 2'd0;
    run(1);
    chk("t6_door_up", door_open, 1);
    run(3);
    chk("t6_open_c3", door_open, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_door", door_open, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_last_grant", last_grant, 1);
    exit_req = 1'b0;
    @(posedge clk); #1;
    chk("t6_held_door", door_open, 0);
    reset = 1'b1;
    clr_cnt();
    run(1);
    chk("t6_no_early_signal", entry_signal, 0);
    run(1);
    chk("t6_regrant", entry_signal, 1);
    run(13);
    chk("t6_exit_discarded", n_exit + n_rs, 0);
    chk("t6_single_entry", n_entry, 1);
    chk("t6_idle", busy, 0);

    chk("pulse_rules", n_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
